// File: rtl/data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : data_mem_ctrl
// Description : Memory-stage data memory responder. Performs byte/half/word
//               loads and stores against an internal word-organised RAM with
//               LATENCY wait states, stalling the pipeline until the access
//               completes. Load data is registered toward the M/W register.
// Ports       : clk, rst_n (async, active low)
//               MemWriteM   - store request
//               ResultSrcM  - 2'b01 marks a load request
//               Funct3M     - access size / signedness (B,H,W,BU,HU)
//               ALUOutM     - byte address
//               WriteDataM  - right-aligned store data
//               ReadDataM   - extended load result (registered)
//               StallM      - hold upstream stages this cycle
//               MisalignM   - request misaligned, access suppressed
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The request cycle itself is the first stalled cycle, so WAIT only has to
  // cover the remaining LATENCY-1 cycles (counted down to zero).
  localparam logic [3:0] c_wait_init = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         c_zero_lat  = (LATENCY == 0);
  localparam bit         c_one_lat   = (LATENCY == 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [2:0]            r_f3;
  logic [31:0]           r_wdata;
  logic                  r_store;

  logic [31:0] r_mem [2**ADDR_WIDTH];

  logic                  w_req;
  logic                  w_misalign_in;
  logic                  w_new_ok;
  logic                  w_acc_en;
  logic                  w_acc_store;
  logic [ADDR_WIDTH+1:0] w_acc_addr;
  logic [2:0]            w_acc_f3;
  logic [31:0]           w_acc_wdata;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [31:0]           w_lane_data;
  logic [31:0]           w_rword;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic [31:0]           w_load_val;
  logic                  w_unused;

  // Upper address bits alias onto the RAM.
  assign w_unused = &{1'b0, ALUOutM[31:ADDR_WIDTH+2]};

  // A simultaneous load flag is irrelevant: MemWriteM alone decides direction.
  assign w_req = MemWriteM | (ResultSrcM == 2'b01);

  // Funct3 low bits select size: 00 byte, 01 half, anything else word.
  always_comb begin
    w_misalign_in = 1'b0;
    case (Funct3M[1:0])
      2'b00:   w_misalign_in = 1'b0;
      2'b01:   w_misalign_in = ALUOutM[0];
      default: w_misalign_in = |ALUOutM[1:0];
    endcase
  end

  // Outputs are gated by rst_n so a held request cannot stall while in reset.
  assign w_new_ok  = rst_n && (r_state == S_IDLE) && w_req && !w_misalign_in;
  assign MisalignM = rst_n && (r_state == S_IDLE) && w_req && w_misalign_in;
  assign StallM    = rst_n && ((w_new_ok && !c_zero_lat) || (r_state == S_WAIT));

  // Access happens from the latched request in RESP, or straight from the
  // inputs when there are no wait states.
  assign w_acc_en    = rst_n && ((r_state == S_RESP) || (c_zero_lat && w_new_ok));
  assign w_acc_store = (r_state == S_RESP) ? r_store : MemWriteM;
  assign w_acc_addr  = (r_state == S_RESP) ? r_addr  : ALUOutM[ADDR_WIDTH+1:0];
  assign w_acc_f3    = (r_state == S_RESP) ? r_f3    : Funct3M;
  assign w_acc_wdata = (r_state == S_RESP) ? r_wdata : WriteDataM;
  assign w_idx       = w_acc_addr[ADDR_WIDTH+1:2];
  assign w_lane      = w_acc_addr[1:0];

  always_comb begin
    w_be        = 4'b1111;
    w_lane_data = w_acc_wdata;
    if (w_acc_f3[1:0] == 2'b00) begin
      w_be        = 4'b0001 << w_lane;
      w_lane_data = {4{w_acc_wdata[7:0]}};
    end else if (w_acc_f3[1:0] == 2'b01) begin
      w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
      w_lane_data = {2{w_acc_wdata[15:0]}};
    end
  end

  assign w_rword = r_mem[w_idx];
  assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];
  assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  // Funct3[2] marks the unsigned variants (BU/HU).
  always_comb begin
    w_load_val = w_rword;
    if (w_acc_f3[1:0] == 2'b00)
      w_load_val = w_acc_f3[2] ? {24'd0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
    else if (w_acc_f3[1:0] == 2'b01)
      w_load_val = w_acc_f3[2] ? {16'd0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
  end

  // RAM is not reset; w_acc_en already blocks writes while rst_n is low.
  always_ff @(posedge clk) begin
    if (w_acc_en && w_acc_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_f3      <= 3'd0;
      r_wdata   <= 32'd0;
      r_store   <= 1'b0;
      ReadDataM <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_misalign_in) begin
              ReadDataM <= 32'd0;
            end else if (c_zero_lat) begin
              if (!MemWriteM) ReadDataM <= w_load_val;
            end else begin
              r_addr  <= ALUOutM[ADDR_WIDTH+1:0];
              r_f3    <= Funct3M;
              r_wdata <= WriteDataM;
              r_store <= MemWriteM;
              r_cnt   <= c_wait_init;
              r_state <= c_one_lat ? S_RESP : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          // Held inputs are ignored here; the request is not re-issued.
          if (!r_store) ReadDataM <= w_load_val;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed self-checking bench for data_mem_ctrl. One instance
//               with LATENCY=2 and one with LATENCY=0 share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam logic [2:0] c_b  = 3'b000;
  localparam logic [2:0] c_h  = 3'b001;
  localparam logic [2:0] c_w  = 3'b010;
  localparam logic [2:0] c_bu = 3'b100;
  localparam logic [2:0] c_hu = 3'b101;
  localparam logic [1:0] c_ld = 2'b01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        we2, st2, mis2;
  logic [1:0]  rs2;
  logic [2:0]  f32;
  logic [31:0] a2, wd2, rd2;
  logic        we0, st0, mis0;
  logic [1:0]  rs0;
  logic [2:0]  f30;
  logic [31:0] a0, wd0, rd0;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .MemWriteM(we2), .ResultSrcM(rs2), .Funct3M(f32),
    .ALUOutM(a2), .WriteDataM(wd2), .ReadDataM(rd2), .StallM(st2), .MisalignM(mis2)
  );

  data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst_n(rst_n), .MemWriteM(we0), .ResultSrcM(rs0), .Funct3M(f30),
    .ALUOutM(a0), .WriteDataM(wd0), .ReadDataM(rd0), .StallM(st0), .MisalignM(mis0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1. Holds the request (including through RESP) and
  // returns at posedge+1 after the completing edge with inputs cleared.
  task automatic req2(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int stalls, output logic mis);
    we2 = we; rs2 = rs; f32 = f3; a2 = addr; wd2 = wd;
    #1;
    mis    = mis2;
    stalls = 0;
    while (st2 === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    we2 = 1'b0; rs2 = 2'b00; f32 = 3'd0; a2 = 32'd0; wd2 = 32'd0;
  endtask

  // Single-cycle request on the zero-latency instance; inputs left as driven.
  task automatic req0(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic stall, output logic mis);
    we0 = we; rs0 = rs; f30 = f3; a0 = addr; wd0 = wd;
    #1;
    stall = st0;
    mis   = mis0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   s;
    logic m;
    logic s0a, s0b;

    rst_n = 1'b0;
    we2 = 1'b0; rs2 = 2'b00; f32 = 3'd0; a2 = 32'd0; wd2 = 32'd0;
    we0 = 1'b0; rs0 = 2'b00; f30 = 3'd0; a0 = 32'd0; wd0 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd2", rd2, 32'd0);
    chk("rst_stall2", {31'd0, st2}, 32'd0);
    chk("rst_mis2", {31'd0, mis2}, 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then load, two stall cycles each.
    req2(1'b1, 2'b00, c_w, 32'h40, 32'hDEADBEEF, s, m);
    chk("sw_stalls", s, 2);
    chk("sw_no_mis", {31'd0, m}, 32'd0);
    chk("sw_keeps_rd", rd2, 32'd0);
    req2(1'b0, c_ld, c_w, 32'h40, 32'd0, s, m);
    chk("lw_stalls", s, 2);
    chk("lw_data", rd2, 32'hDEADBEEF);
    // Held request through RESP must not start another stall burst.
    #1;
    chk("no_reissue_a", {31'd0, st2}, 32'd0);
    @(posedge clk); #1;
    chk("no_reissue_b", {31'd0, st2}, 32'd0);

    // Byte lane store and sign/zero-extended byte loads.
    req2(1'b1, 2'b00, c_w, 32'h40, 32'h00000000, s, m);
    req2(1'b1, 2'b00, c_b, 32'h41, 32'hAAAAAA80, s, m);
    req2(1'b0, c_ld, c_b, 32'h41, 32'd0, s, m);
    chk("lb_41", rd2, 32'hFFFFFF80);
    req2(1'b0, c_ld, c_bu, 32'h41, 32'd0, s, m);
    chk("lbu_41", rd2, 32'h00000080);
    req2(1'b0, c_ld, c_w, 32'h40, 32'd0, s, m);
    chk("lw_after_sb", rd2, 32'h00008000);

    // Upper half store and half loads.
    req2(1'b1, 2'b00, c_h, 32'h42, 32'h5555F234, s, m);
    req2(1'b0, c_ld, c_h, 32'h42, 32'd0, s, m);
    chk("lh_42", rd2, 32'hFFFFF234);
    req2(1'b0, c_ld, c_hu, 32'h42, 32'd0, s, m);
    chk("lhu_42", rd2, 32'h0000F234);
    // Bit 12 lies above the word index and aliases back to 0x40.
    req2(1'b0, c_ld, c_w, 32'h1040, 32'd0, s, m);
    chk("lw_alias", rd2, 32'hF2348000);

    // Misaligned accesses.
    req2(1'b0, c_ld, c_h, 32'h43, 32'd0, s, m);
    chk("lh43_mis", {31'd0, m}, 32'd1);
    chk("lh43_stall", s, 0);
    chk("lh43_rd", rd2, 32'd0);
    req2(1'b1, 2'b00, c_w, 32'h42, 32'h11111111, s, m);
    chk("sw42_mis", {31'd0, m}, 32'd1);
    chk("sw42_stall", s, 0);
    req2(1'b0, c_ld, 3'b011, 32'h42, 32'd0, s, m);
    chk("f3_011_as_w_mis", {31'd0, m}, 32'd1);
    req2(1'b0, c_ld, c_w, 32'h40, 32'd0, s, m);
    chk("mem_unchanged", rd2, 32'hF2348000);

    // Reset while a store is waiting: it must not commit.
    req2(1'b1, 2'b00, c_w, 32'h10, 32'hCAFEF00D, s, m);
    we2 = 1'b1; rs2 = 2'b00; f32 = c_w; a2 = 32'h10; wd2 = 32'h12345678;
    @(posedge clk); #1;
    chk("wait_stall", {31'd0, st2}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall_now", {31'd0, st2}, 32'd0);
    chk("rst_rd_now", rd2, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    we2 = 1'b0; rs2 = 2'b00; f32 = 3'd0; a2 = 32'd0; wd2 = 32'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req2(1'b0, c_ld, c_w, 32'h10, 32'd0, s, m);
    chk("aborted_store", rd2, 32'hCAFEF00D);

    // Zero-latency instance: back-to-back store/load, never stalls.
    req0(1'b1, 2'b00, c_w, 32'h20, 32'h0BADF00D, s0a, m);
    req0(1'b0, c_ld, c_w, 32'h20, 32'd0, s0b, m);
    chk("l0_sw_stall", {31'd0, s0a}, 32'd0);
    chk("l0_lw_stall", {31'd0, s0b}, 32'd0);
    chk("l0_lw_data", rd0, 32'h0BADF00D);
    req0(1'b1, 2'b00, c_b, 32'h23, 32'h0000007F, s0a, m);
    req0(1'b0, c_ld, c_b, 32'h23, 32'd0, s0b, m);
    chk("l0_lb_23", rd0, 32'h0000007F);
    chk("l0_sb_stall", {31'd0, s0a | s0b}, 32'd0);
    req0(1'b0, c_ld, c_w, 32'h20, 32'd0, s0a, m);
    chk("l0_lw_merge", rd0, 32'h7FADF00D);
    req0(1'b0, c_ld, c_h, 32'h21, 32'd0, s0a, m);
    chk("l0_mis", {31'd0, m}, 32'd1);
    chk("l0_mis_rd", rd0, 32'd0);
    we0 = 1'b0; rs0 = 2'b00; f30 = 3'd0; a0 = 32'd0; wd0 = 32'd0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
